corevx_tlb: RTL and testbench
=============================

Name: corevx_tlb

Overview:
- Fully-associative translation cache between the core's load/store/fetch MMU logic and the page table walker.
- Looks up a 20-bit virtual page number and returns the cached 8 access bits and 22-bit physical page number one cycle later, or a miss.
- On a miss the MMU starts a page table walk and writes the walker's result back through the fill port.
- Supports a full flush for SFENCE.VMA and satp writes.

Parameters:
ENTRIES, 16, number of entries; power of two, 2..64
ENTRIES_W, $clog2(ENTRIES), victim pointer / index width (derived, not overridden)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
invalidate  input  1  flush all entries this cycle
resolve_request  input  1  lookup request
resolve_ack  output  1  lookup accepted this cycle
virtual_address  input  20  VPN to look up (VA[31:12])
resolve_done  output  1  lookup result valid (one-cycle pulse)
resolve_miss  output  1  qualifies resolve_done: no matching entry
resolve_access_bits  output  8  cached PTE bits [7:0] (V,R,W,X,U,G,A,D)
resolve_physical_address  output  22  cached PPN (PA[33:12])
new_entry_write  input  1  fill strobe from the walker's successful resolve
new_entry_virtual_address  input  20  VPN of fill
new_entry_access_bits  input  8  access bits of fill
new_entry_physical_address  input  22  PPN of fill; megapage PPN0 already merged by the walker

Behaviour:
- Storage per entry: valid, vpn[19:0], access[7:0], ppn[21:0]. Megapages are cached per 4 KiB VPN; there is no megapage tag.
- Reset: all valid = 0, victim pointer = 0, resolve_done = 0, resolve_miss = 0, resolve_access_bits = 0, resolve_physical_address = 0.
- resolve_ack = !invalidate, combinational.
- Lookup: a request is accepted when resolve_request && resolve_ack at a rising edge.
  - The associative compare uses the contents before that edge.
  - Results are registered, so resolve_done is high for exactly the next cycle. Latency 1, throughput 1 per cycle; back-to-back requests give back-to-back done pulses.
- Hit: resolve_miss = 0; access and ppn outputs come from the matching entry.
- Miss: resolve_miss = 1; access and ppn outputs = 0.
- No accepted request: resolve_done = 0; resolve_miss and data outputs hold their previous values.
- Fill is ignored when new_entry_access_bits[0] (V) = 0. Otherwise:
  - If a valid entry already holds the same VPN, that entry is overwritten and the victim pointer is unchanged.
  - Else the entry at the victim pointer is written (valid = 1), and the pointer increments modulo ENTRIES, wrapping from ENTRIES-1 to 0. Round-robin replacement; invalid entries are not preferred.
- Duplicate VPNs never coexist; at most one entry matches.
- Lookup and fill in the same cycle: the lookup sees pre-fill contents (a same-VPN fill still reports a miss); the fill completes at the same edge.
- Invalidate:
  - At the edge, clears every valid bit and resets the victim pointer to 0.
  - A same-cycle fill is dropped; a same-cycle request is not acked.
  - resolve_done is 0 in the following cycle, unless a request was accepted earlier and its result is already registered.
  - Invalidate held high for multiple cycles keeps the TLB empty and acks nothing.
- Reset mid-operation: everything returns to reset values immediately; a pending done pulse is lost.

Optional Feature:
COREVX_TLB_STATS_EN
- Defined: adds outputs stat_hit_count [31:0] and stat_miss_count [31:0].
  - Each increments on every cycle with resolve_done = 1, according to resolve_miss.
  - Both wrap at 2^32, reset to 0, and are not cleared by invalidate.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then request VPN 0x12345 -> ack = 1; next cycle done = 1, miss = 1, access = 0x00, ppn = 0.
- Fill VPN 0x12345, access 0xCF, ppn 0x2ABCD; then request 0x12345 -> next cycle done = 1, miss = 0, access = 0xCF, ppn = 0x2ABCD.
- With ENTRIES = 16, fill VPNs 0..16 with ppn = VPN+0x100 -> VPN 0 evicted (miss), VPN 16 hits ppn 0x110, VPN 1 hits ppn 0x101. Refilling VPN 5 with ppn 0x999 overwrites in place and leaves the pointer at 1, so the next fill evicts VPN 1.
- Same-cycle request and fill of VPN 0x00042 -> that lookup misses; a request in the next cycle hits. A fill with access 0xCE (V = 0) -> subsequent lookup misses.
- Fill 4 entries, then pulse invalidate with a simultaneous request and fill -> ack = 0 that cycle and the fill is dropped; all 5 VPNs miss afterwards, and the next fill lands in entry 0.
- COREVX_TLB_STATS_EN defined: 3 hits + 2 misses -> stat_hit_count = 3, stat_miss_count = 2, and both unchanged after invalidate.

Source files
------------

// File: rtl/corevx_tlb.sv
// corevx_tlb: fully-associative translation cache in front of the page table walker.
// Lookups return access bits and PPN one cycle after acceptance, or a miss.
// Fills come from the walker; replacement is round-robin with in-place overwrite
// when the VPN is already cached. Invalidate flushes everything.
// Optional build macro COREVX_TLB_STATS_EN adds free-running hit/miss counters.
//
// Handshake: a lookup is accepted at a rising edge when resolve_request and
// resolve_ack are both high; resolve_done pulses for exactly the next cycle and
// qualifies resolve_miss / resolve_access_bits / resolve_physical_address, which
// otherwise hold their last value.
module corevx_tlb #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        invalidate,
    input  logic        resolve_request,
    output logic        resolve_ack,
    input  logic [19:0] virtual_address,
    output logic        resolve_done,
    output logic        resolve_miss,
    output logic [7:0]  resolve_access_bits,
    output logic [21:0] resolve_physical_address,
`ifdef COREVX_TLB_STATS_EN
    output logic [31:0] stat_hit_count,
    output logic [31:0] stat_miss_count,
`endif
    input  logic        new_entry_write,
    input  logic [19:0] new_entry_virtual_address,
    input  logic [7:0]  new_entry_access_bits,
    input  logic [21:0] new_entry_physical_address
);

    localparam int ENTRIES_W = $clog2(ENTRIES);

    // Entry storage
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [19:0]        vpn_q [ENTRIES];
    logic [19:0]        vpn_d [ENTRIES];
    logic [7:0]         acc_q [ENTRIES];
    logic [7:0]         acc_d [ENTRIES];
    logic [21:0]        ppn_q [ENTRIES];
    logic [21:0]        ppn_d [ENTRIES];
    logic [ENTRIES_W-1:0] victim_q, victim_d;

    // Registered lookup result
    logic        done_q, done_d;
    logic        miss_q, miss_d;
    logic [7:0]  racc_q, racc_d;
    logic [21:0] rppn_q, rppn_d;

    // Associative match results
    logic                 look_hit;
    logic [ENTRIES_W-1:0] look_idx;
    logic                 fill_hit;
    logic [ENTRIES_W-1:0] fill_idx;
    logic                 accept;
    logic                 fill_en;
    logic [ENTRIES_W-1:0] wr_idx;

    assign resolve_ack              = !invalidate;
    assign accept                   = resolve_request && resolve_ack;
    assign fill_en                  = new_entry_write && new_entry_access_bits[0] && !invalidate;
    assign resolve_done             = done_q;
    assign resolve_miss             = miss_q;
    assign resolve_access_bits      = racc_q;
    assign resolve_physical_address = ppn_sel_unused_guard(rppn_q);

    function automatic logic [21:0] ppn_sel_unused_guard(input logic [21:0] v);
        return v;
    endfunction

    // Compare both the lookup VPN and the fill VPN against every valid entry;
    // duplicates are never created, so at most one index matches each.
    always_comb begin
        look_hit = 1'b0;
        look_idx = '0;
        fill_hit = 1'b0;
        fill_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && vpn_q[i] == virtual_address) begin
                look_hit = 1'b1;
                look_idx = ENTRIES_W'(i);
            end
            if (valid_q[i] && vpn_q[i] == new_entry_virtual_address) begin
                fill_hit = 1'b1;
                fill_idx = ENTRIES_W'(i);
            end
        end
    end

    // Next-state for the lookup result: updated only on an accepted request.
    always_comb begin
        done_d = accept;
        miss_d = miss_q;
        racc_d = racc_q;
        rppn_d = rppn_q;
        if (accept) begin
            miss_d = !look_hit;
            racc_d = look_hit ? acc_q[look_idx] : 8'h00;
            rppn_d = look_hit ? ppn_q[look_idx] : 22'h0;
        end
    end

    // Next-state for storage: invalidate wins over fill; fills overwrite a
    // same-VPN entry in place, otherwise take the round-robin victim.
    always_comb begin
        valid_d  = valid_q;
        vpn_d    = vpn_q;
        acc_d    = acc_q;
        ppn_d    = ppn_q;
        victim_d = victim_q;
        wr_idx   = fill_hit ? fill_idx : victim_q;
        if (invalidate) begin
            valid_d  = '0;
            victim_d = '0;
        end else if (fill_en) begin
            valid_d[wr_idx] = 1'b1;
            vpn_d[wr_idx]   = new_entry_virtual_address;
            acc_d[wr_idx]   = new_entry_access_bits;
            ppn_d[wr_idx]   = new_entry_physical_address;
            if (!fill_hit) begin
                victim_d = victim_q + ENTRIES_W'(1);
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            victim_q <= '0;
            done_q   <= 1'b0;
            miss_q   <= 1'b0;
            racc_q   <= 8'h00;
            rppn_q   <= 22'h0;
            for (int i = 0; i < ENTRIES; i++) begin
                vpn_q[i] <= '0;
                acc_q[i] <= '0;
                ppn_q[i] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            victim_q <= victim_d;
            done_q   <= done_d;
            miss_q   <= miss_d;
            racc_q   <= racc_d;
            rppn_q   <= rppn_d;
            for (int i = 0; i < ENTRIES; i++) begin
                vpn_q[i] <= vpn_d[i];
                acc_q[i] <= acc_d[i];
                ppn_q[i] <= ppn_d[i];
            end
        end
    end

`ifdef COREVX_TLB_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    assign stat_hit_count  = hit_cnt_q;
    assign stat_miss_count = miss_cnt_q;

    // Count each done pulse as a hit or a miss; invalidate does not clear these.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (done_q) begin
            if (miss_q) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end else begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_corevx_tlb.sv
// tb_corevx_tlb: randomized and directed stimulus for corevx_tlb against a
// table-based reference model; results are checked by a decoupled monitor.
module tb_corevx_tlb;

    localparam int N = 16;

    logic        clk;
    logic        rst_n;
    logic        invalidate;
    logic        resolve_request;
    logic        resolve_ack;
    logic [19:0] virtual_address;
    logic        resolve_done;
    logic        resolve_miss;
    logic [7:0]  resolve_access_bits;
    logic [21:0] resolve_physical_address;
    logic        new_entry_write;
    logic [19:0] new_entry_virtual_address;
    logic [7:0]  new_entry_access_bits;
    logic [21:0] new_entry_physical_address;
`ifdef COREVX_TLB_STATS_EN
    logic [31:0] stat_hit_count;
    logic [31:0] stat_miss_count;
`endif

    corevx_tlb #(.ENTRIES(N)) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .invalidate                 (invalidate),
        .resolve_request            (resolve_request),
        .resolve_ack                (resolve_ack),
        .virtual_address            (virtual_address),
        .resolve_done               (resolve_done),
        .resolve_miss               (resolve_miss),
        .resolve_access_bits        (resolve_access_bits),
        .resolve_physical_address   (resolve_physical_address),
`ifdef COREVX_TLB_STATS_EN
        .stat_hit_count             (stat_hit_count),
        .stat_miss_count            (stat_miss_count),
`endif
        .new_entry_write            (new_entry_write),
        .new_entry_virtual_address  (new_entry_virtual_address),
        .new_entry_access_bits      (new_entry_access_bits),
        .new_entry_physical_address (new_entry_physical_address)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- counters / check ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Cache as a list of slots plus the round-robin pointer.
    bit          m_valid [N];
    logic [19:0] m_vpn   [N];
    logic [7:0]  m_acc   [N];
    logic [21:0] m_ppn   [N];
    int          m_ptr;
    int          m_hits  = 0;
    int          m_misses = 0;

    function automatic int m_find(input logic [19:0] vpn);
        for (int i = 0; i < N; i++)
            if (m_valid[i] && m_vpn[i] == vpn) return i;
        return -1;
    endfunction

    task automatic m_flush();
        for (int i = 0; i < N; i++) m_valid[i] = 0;
        m_ptr = 0;
    endtask

    task automatic m_fill(input logic [19:0] vpn, input logic [7:0] acc, input logic [21:0] ppn);
        int slot;
        if (!acc[0]) return;
        slot = m_find(vpn);
        if (slot < 0) begin
            slot  = m_ptr;
            m_ptr = (m_ptr + 1) % N;
        end
        m_valid[slot] = 1;
        m_vpn[slot]   = vpn;
        m_acc[slot]   = acc;
        m_ppn[slot]   = ppn;
    endtask

    // ---------------- scoreboard ----------------
    logic [30:0] exp_q[$];     // {miss, access, ppn}
    int          exp_cyc_q[$]; // cycle in which done must be seen
    logic [30:0] last_exp = '0;
    bit          mon_en = 0;

    // ---------------- driver ----------------
    // One clock cycle of stimulus; entered and left just after a rising edge.
    task automatic drive(input bit req, input logic [19:0] va,
                         input bit wr, input logic [19:0] wva, input logic [7:0] wacc,
                         input logic [21:0] wppn, input bit inv);
        int slot;
        resolve_request            = req;
        virtual_address            = va;
        new_entry_write            = wr;
        new_entry_virtual_address  = wva;
        new_entry_access_bits      = wacc;
        new_entry_physical_address = wppn;
        invalidate                 = inv;
        #1;
        chk("ack", {31'b0, resolve_ack}, {31'b0, !inv});
        if (req && !inv) begin
            slot = m_find(va);
            if (slot < 0) exp_q.push_back({1'b1, 8'h00, 22'h0});
            else          exp_q.push_back({1'b0, m_acc[slot], m_ppn[slot]});
            exp_cyc_q.push_back(cyc + 1);
        end
        if (inv)     m_flush();
        else if (wr) m_fill(wva, wacc, wppn);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 20'h0, 0, 20'h0, 8'h00, 22'h0, 0);
    endtask

    task automatic req(input logic [19:0] va);
        drive(1, va, 0, 20'h0, 8'h00, 22'h0, 0);
    endtask

    task automatic fill(input logic [19:0] va, input logic [7:0] acc, input logic [21:0] ppn);
        drive(0, 20'h0, 1, va, acc, ppn, 0);
    endtask

    task automatic flush();
        drive(0, 20'h0, 0, 20'h0, 8'h00, 22'h0, 1);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [30:0] e;
        if (rst_n && mon_en) begin
            while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
                chk("missing_done", 32'd0, 32'd1);
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
            if (resolve_done) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_cycle", cyc, exp_cyc_q.pop_front());
                    chk("result", {1'b0, resolve_miss, resolve_access_bits, resolve_physical_address}, {1'b0, e});
                    if (e[30]) m_misses++;
                    else       m_hits++;
                    last_exp = e;
                end
            end else begin
                chk("hold", {1'b0, resolve_miss, resolve_access_bits, resolve_physical_address}, {1'b0, last_exp});
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        resolve_request = 0; virtual_address = 0; invalidate = 0;
        new_entry_write = 0; new_entry_virtual_address = 0;
        new_entry_access_bits = 0; new_entry_physical_address = 0;
        m_flush();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_done", {31'b0, resolve_done}, 32'd0);
        chk("reset_miss", {31'b0, resolve_miss}, 32'd0);
        chk("reset_acc",  {24'b0, resolve_access_bits}, 32'd0);
        chk("reset_ppn",  {10'b0, resolve_physical_address}, 32'd0);
        rst_n = 1;
        @(posedge clk);
        #1;
        mon_en = 1;

        // Cold miss, then fill and hit.
        req(20'h12345);
        fill(20'h12345, 8'hCF, 22'h2ABCD);
        req(20'h12345);
        idle();

        // Round-robin eviction and in-place overwrite.
        flush();
        for (int v = 0; v <= 16; v++) fill(20'(v), 8'hCF, 22'(v + 'h100));
        req(20'd0); req(20'd16); req(20'd1);
        fill(20'd5, 8'hCF, 22'h999);
        req(20'd5);
        fill(20'h777, 8'hC7, 22'h777);
        req(20'd1); req(20'h777); req(20'd2);
        idle();

        // Same-cycle request and fill; fill with V clear.
        drive(1, 20'h00042, 1, 20'h00042, 8'hCF, 22'h42, 0);
        req(20'h00042);
        fill(20'h00055, 8'hCE, 22'h55);
        req(20'h00055);
        idle();

        // Invalidate with concurrent request and fill.
        flush();
        for (int v = 0; v < 4; v++) fill(20'(v + 'h300), 8'hFF, 22'(v + 'h3000));
        drive(1, 20'h300, 1, 20'h304, 8'hFF, 22'h3004, 1);
        for (int v = 0; v < 5; v++) req(20'(v + 'h300));
        fill(20'h400, 8'h01, 22'h400);
        for (int v = 1; v <= 16; v++) fill(20'(v + 'h400), 8'h01, 22'(v + 'h400));
        req(20'h400); req(20'h401); req(20'h410);
        flush(); flush();
        req(20'h401);

        // Randomized traffic over a small VPN pool to mix hits, misses and evictions.
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 2) != 0, 20'($urandom_range(0, 23)),
                  $urandom_range(0, 1) == 1, 20'($urandom_range(0, 23)),
                  8'($urandom_range(0, 255)), 22'($urandom),
                  $urandom_range(0, 29) == 0);
        end

        repeat (3) idle();
        chk("queue_drained", exp_q.size(), 32'd0);
`ifdef COREVX_TLB_STATS_EN
        chk("stat_hits",   stat_hit_count,  m_hits);
        chk("stat_misses", stat_miss_count, m_misses);
        flush();
        chk("stat_hits_after_inv",   stat_hit_count,  m_hits);
        chk("stat_misses_after_inv", stat_miss_count, m_misses);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
